// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: datapath width, length-byte address and encrypt FSM states.
package arc4_pkg;

  localparam int MEM_W = 8;
  localparam logic [MEM_W-1:0] LEN_ADDR = 8'h00;

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WR_LEN,
    INC,
    RD_I,
    RD_J,
    WR_J,
    RD_PAD,
    WR_CT
  } enc_state_t;

endpackage

// File: rtl/arc4_encrypt.sv
// ARC4 encrypt: reads length-prefixed plaintext, runs the PRGA over a
// key-scheduled S array and writes length-prefixed ciphertext.
// All memory-facing outputs are flops; a state's actions are loaded at the
// edge leaving it, and the memory's read data for that address is consumed
// at the edge after, so read data never reaches an output port combinationally.
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic [MEM_W-1:0] s_addr,
  input  logic [MEM_W-1:0] s_rddata,
  output logic [MEM_W-1:0] s_wrdata,
  output logic             s_wren,
  output logic [MEM_W-1:0] pt_addr,
  input  logic [MEM_W-1:0] pt_rddata,
  output logic [MEM_W-1:0] ct_addr,
  output logic [MEM_W-1:0] ct_wrdata,
  output logic             ct_wren
);

  enc_state_t       state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [MEM_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [MEM_W-1:0] si_q, si_d, sj_q, sj_d, len_q, len_d;
  logic [MEM_W-1:0] s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
  logic [MEM_W-1:0] pt_addr_q, pt_addr_d;
  logic [MEM_W-1:0] ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
  logic             s_wren_q, s_wren_d, ct_wren_q, ct_wren_d;

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign pt_addr   = pt_addr_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign ct_wren   = ct_wren_q;

  // Next-state and datapath: one PRGA byte every six states.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    len_d       = len_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    s_wren_d    = 1'b0;
    ct_wren_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && rdy_q) begin
          state_d = RD_LEN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RD_LEN: begin
        pt_addr_d = LEN_ADDR;
        state_d   = WR_LEN;
      end
      WR_LEN: begin
        len_d       = pt_rddata;
        ct_addr_d   = LEN_ADDR;
        ct_wrdata_d = pt_rddata;
        ct_wren_d   = 1'b1;
        if (pt_rddata == '0) begin
          state_d = IDLE;
        end else begin
          k_d     = 8'd1;
          state_d = INC;
        end
      end
      INC: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        state_d  = RD_I;
      end
      RD_I: begin
        si_d     = s_rddata;
        j_d      = j_q + s_rddata;
        s_addr_d = j_q + s_rddata;
        state_d  = RD_J;
      end
      RD_J: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = WR_J;
      end
      WR_J: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        state_d    = RD_PAD;
      end
      RD_PAD: begin
        s_addr_d  = si_q + sj_q;
        pt_addr_d = k_q;
        state_d   = WR_CT;
      end
      WR_CT: begin
        ct_addr_d   = k_q;
        ct_wrdata_d = s_rddata ^ pt_rddata;
        ct_wren_d   = 1'b1;
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = INC;
        end
      end
      default: state_d = IDLE;
    endcase
    // rdy waits one extra cycle after returning to IDLE so the final
    // ciphertext write lands before the next start can be accepted.
    rdy_d = (state_d == IDLE) && (state_q == IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      len_q       <= '0;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      pt_addr_q   <= '0;
      ct_addr_q   <= '0;
      ct_wrdata_q <= '0;
      ct_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      len_q       <= len_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
    end
  end

endmodule
